hand_datapath: RTL and testbench

Card-holding datapath directly downstream of the round state machine. It consumes the six load strobes and the two win lights, and latches the dealt card into the addressed slot. It returns pscore, dscore and pcard3 to the state machine, exports all six cards for the HEX display decoders, and keeps running win/tie tallies across rounds.

---
 rtl/hand_datapath.sv | 160 ++++++++++++++++
 tb/tb_hand_datapath.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/hand_datapath.sv
// Baccarat hand datapath: latches dealt cards into slots in deal order, forms both
// hand scores combinationally and keeps saturating win/tie tallies across rounds.
module hand_datapath #(
   parameter int TALLY_W = 8
) (
   input  logic               slow_clock,
   input  logic               reset,
   input  logic               new_round,
   input  logic [3:0]         new_card,
   input  logic               load_pcard1,
   input  logic               load_pcard2,
   input  logic               load_pcard3,
   input  logic               load_dcard1,
   input  logic               load_dcard2,
   input  logic               load_dcard3,
   input  logic               player_win_light,
   input  logic               dealer_win_light,
   output logic [3:0]         pcard1,
   output logic [3:0]         pcard2,
   output logic [3:0]         pcard3,
   output logic [3:0]         dcard1,
   output logic [3:0]         dcard2,
   output logic [3:0]         dcard3,
   output logic [3:0]         pscore,
   output logic [3:0]         dscore,
   output logic [TALLY_W-1:0] player_wins,
   output logic [TALLY_W-1:0] dealer_wins,
   output logic [TALLY_W-1:0] ties,
   output logic               seq_error,
   output logic               bad_card
);

   typedef enum logic [2:0] {
      EXPECT_P1, EXPECT_D1, EXPECT_P2, EXPECT_D2, EXPECT_3RD, EXPECT_D3, DONE
   } slot_t;

   localparam logic [TALLY_W-1:0] TALLY_ONE = {{(TALLY_W-1){1'b0}}, 1'b1};

   // Strobe bit order: p1, p2, p3, d1, d2, d3 from LSB.
   localparam logic [5:0] S_P1 = 6'b000001;
   localparam logic [5:0] S_P2 = 6'b000010;
   localparam logic [5:0] S_P3 = 6'b000100;
   localparam logic [5:0] S_D1 = 6'b001000;
   localparam logic [5:0] S_D2 = 6'b010000;
   localparam logic [5:0] S_D3 = 6'b100000;

   function automatic logic [4:0] pts(input logic [3:0] card);
      return (card >= 4'd1 && card <= 4'd9) ? {1'b0, card} : 5'd0;
   endfunction

   // Sum never exceeds 27, so two conditional subtracts replace a divider.
   function automatic logic [3:0] mod10(input logic [4:0] sum);
      logic [4:0] r;
      if (sum >= 5'd20)      r = sum - 5'd20;
      else if (sum >= 5'd10) r = sum - 5'd10;
      else                   r = sum;
      return r[3:0];
   endfunction

   function automatic logic [TALLY_W-1:0] sat_inc(input logic [TALLY_W-1:0] v);
      return (&v) ? v : v + TALLY_ONE;
   endfunction

   slot_t      state;
   logic       res_q;
   logic [5:0] strobes;
   logic       any_strobe;
   logic       match;
   logic       card_ok;
   logic       res_now;
   logic       res_edge;

   assign strobes    = {load_dcard3, load_dcard2, load_dcard1,
                        load_pcard3, load_pcard2, load_pcard1};
   assign any_strobe = |strobes;
   assign card_ok    = (new_card >= 4'd1) && (new_card <= 4'd13);
   assign res_now    = player_win_light | dealer_win_light;
   assign res_edge   = res_now & ~res_q;

   // A match requires the strobe vector to equal one expected one-hot pattern,
   // so simultaneous strobes are never a match.
   always_comb begin
      match = 1'b0;
      case (state)
         EXPECT_P1:  match = (strobes == S_P1);
         EXPECT_D1:  match = (strobes == S_D1);
         EXPECT_P2:  match = (strobes == S_P2);
         EXPECT_D2:  match = (strobes == S_D2);
         EXPECT_3RD: match = (strobes == S_P3) || (strobes == S_D3);
         EXPECT_D3:  match = (strobes == S_D3);
         default:    match = 1'b0;
      endcase
   end

   assign pscore = mod10(pts(pcard1) + pts(pcard2) + pts(pcard3));
   assign dscore = mod10(pts(dcard1) + pts(dcard2) + pts(dcard3));

   always_ff @(posedge slow_clock) begin
      if (reset) begin
         state       <= EXPECT_P1;
         pcard1      <= 4'd0;
         pcard2      <= 4'd0;
         pcard3      <= 4'd0;
         dcard1      <= 4'd0;
         dcard2      <= 4'd0;
         dcard3      <= 4'd0;
         seq_error   <= 1'b0;
         bad_card    <= 1'b0;
         res_q       <= 1'b0;
         player_wins <= '0;
         dealer_wins <= '0;
         ties        <= '0;
      end else begin
         // Tallies advance even in a new_round cycle.
         if (res_edge) begin
            if (player_win_light && !dealer_win_light) player_wins <= sat_inc(player_wins);
            if (dealer_win_light && !player_win_light) dealer_wins <= sat_inc(dealer_wins);
            if (player_win_light && dealer_win_light)  ties        <= sat_inc(ties);
         end
         if (new_round) begin
            state     <= EXPECT_P1;
            pcard1    <= 4'd0;
            pcard2    <= 4'd0;
            pcard3    <= 4'd0;
            dcard1    <= 4'd0;
            dcard2    <= 4'd0;
            dcard3    <= 4'd0;
            seq_error <= 1'b0;
            bad_card  <= 1'b0;
            res_q     <= 1'b0;
         end else begin
            res_q <= res_now;
            if (any_strobe && !match) begin
               seq_error <= 1'b1;
            end else if (any_strobe && !card_ok) begin
               bad_card <= 1'b1;
            end else if (any_strobe) begin
               case (state)
                  EXPECT_P1: begin pcard1 <= new_card; state <= EXPECT_D1; end
                  EXPECT_D1: begin dcard1 <= new_card; state <= EXPECT_P2; end
                  EXPECT_P2: begin pcard2 <= new_card; state <= EXPECT_D2; end
                  EXPECT_D2: begin dcard2 <= new_card; state <= EXPECT_3RD; end
                  EXPECT_3RD: begin
                     if (load_pcard3) begin
                        pcard3 <= new_card;
                        state  <= EXPECT_D3;
                     end else begin
                        dcard3 <= new_card;
                        state  <= DONE;
                     end
                  end
                  EXPECT_D3: begin dcard3 <= new_card; state <= DONE; end
                  default:   state <= state;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_hand_datapath.sv
// Directed bench for hand_datapath: card loading order, error flags, scores and
// saturating tallies with TALLY_W=2, all expected values worked out by hand.
module tb_hand_datapath;

   localparam int TW = 2;

   logic          slow_clock = 1'b0;
   logic          reset = 1'b1;
   logic          new_round = 1'b0;
   logic [3:0]    new_card = 4'd0;
   logic [5:0]    strb = 6'd0;
   logic          player_win_light = 1'b0;
   logic          dealer_win_light = 1'b0;
   logic [3:0]    pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
   logic [3:0]    pscore, dscore;
   logic [TW-1:0] player_wins, dealer_wins, ties;
   logic          seq_error, bad_card;

   int checks = 0;
   int failures = 0;

   localparam logic [5:0] P1 = 6'b000001, P2 = 6'b000010, P3 = 6'b000100;
   localparam logic [5:0] D1 = 6'b001000, D2 = 6'b010000, D3 = 6'b100000;

   always #5 slow_clock = ~slow_clock;

   hand_datapath #(.TALLY_W(TW)) dut (
      .slow_clock(slow_clock),
      .reset(reset),
      .new_round(new_round),
      .new_card(new_card),
      .load_pcard1(strb[0]),
      .load_pcard2(strb[1]),
      .load_pcard3(strb[2]),
      .load_dcard1(strb[3]),
      .load_dcard2(strb[4]),
      .load_dcard3(strb[5]),
      .player_win_light(player_win_light),
      .dealer_win_light(dealer_win_light),
      .pcard1(pcard1),
      .pcard2(pcard2),
      .pcard3(pcard3),
      .dcard1(dcard1),
      .dcard2(dcard2),
      .dcard3(dcard3),
      .pscore(pscore),
      .dscore(dscore),
      .player_wins(player_wins),
      .dealer_wins(dealer_wins),
      .ties(ties),
      .seq_error(seq_error),
      .bad_card(bad_card)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge slow_clock);
      #1;
   endtask

   task automatic load(input logic [5:0] mask, input logic [3:0] card);
      strb     = mask;
      new_card = card;
      tick();
      strb     = 6'd0;
      new_card = 4'd0;
   endtask

   task automatic do_new_round();
      new_round = 1'b1;
      tick();
      new_round = 1'b0;
   endtask

   task automatic pulse(input logic p, input logic d);
      player_win_light = p;
      dealer_win_light = d;
      tick();
      player_win_light = 1'b0;
      dealer_win_light = 1'b0;
      tick();
   endtask

   initial begin
      tick();
      tick();
      reset = 1'b0;
      check_eq("rst_pcard1", pcard1, 0);
      check_eq("rst_dcard3", dcard3, 0);
      check_eq("rst_pscore", pscore, 0);
      check_eq("rst_seq", seq_error, 0);
      check_eq("rst_bad", bad_card, 0);
      check_eq("rst_pw", player_wins, 0);
      check_eq("rst_ties", ties, 0);

      // Four legal cards.
      load(P1, 4'd7);
      load(D1, 4'd13);
      load(P2, 4'd5);
      load(D2, 4'd4);
      check_eq("h1_pcard1", pcard1, 7);
      check_eq("h1_dcard1", dcard1, 13);
      check_eq("h1_pcard2", pcard2, 5);
      check_eq("h1_dcard2", dcard2, 4);
      check_eq("h1_pscore", pscore, 2);
      check_eq("h1_dscore", dscore, 4);
      check_eq("h1_seq", seq_error, 0);

      // Full six-card hand, then an extra load after DONE.
      do_new_round();
      check_eq("nr_pcard1", pcard1, 0);
      load(P1, 4'd9);
      load(D1, 4'd9);
      load(P2, 4'd9);
      load(D2, 4'd9);
      load(P3, 4'd8);
      load(D3, 4'd1);
      check_eq("h2_pcard3", pcard3, 8);
      check_eq("h2_pscore", pscore, 6);
      check_eq("h2_dscore", dscore, 9);
      check_eq("h2_seq_pre", seq_error, 0);
      load(D3, 4'd5);
      check_eq("h2_seq_done", seq_error, 1);
      check_eq("h2_dcard3", dcard3, 1);

      // Player stands: dealer third card straight from EXPECT_3RD.
      do_new_round();
      check_eq("nr_seq_clr", seq_error, 0);
      load(P1, 4'd1);
      load(D1, 4'd2);
      load(P2, 4'd3);
      load(D2, 4'd4);
      load(D3, 4'd3);
      check_eq("h3_pcard3", pcard3, 0);
      check_eq("h3_dcard3", dcard3, 3);
      check_eq("h3_seq", seq_error, 0);
      check_eq("h3_pscore", pscore, 4);
      check_eq("h3_dscore", dscore, 9);

      // Out-of-order and double strobes.
      do_new_round();
      load(P2, 4'd5);
      check_eq("ooo_seq", seq_error, 1);
      check_eq("ooo_pcard2", pcard2, 0);
      check_eq("ooo_pcard1", pcard1, 0);
      do_new_round();
      load(P1 | D1, 4'd5);
      check_eq("dbl_seq", seq_error, 1);
      check_eq("dbl_pcard1", pcard1, 0);
      check_eq("dbl_dcard1", dcard1, 0);
      load(P1, 4'd2);
      check_eq("dbl_ptr_kept", pcard1, 2);
      check_eq("dbl_seq_sticky", seq_error, 1);

      // Illegal card values on legal strobes.
      do_new_round();
      check_eq("nr_bad_clr", bad_card, 0);
      load(P1, 4'd0);
      check_eq("bc0_bad", bad_card, 1);
      check_eq("bc0_pcard1", pcard1, 0);
      check_eq("bc0_seq", seq_error, 0);
      load(P1, 4'd15);
      check_eq("bc15_pcard1", pcard1, 0);
      load(P1, 4'd6);
      check_eq("bc_pcard1_ok", pcard1, 6);
      load(D1, 4'd14);
      check_eq("bc14_dcard1", dcard1, 0);
      load(D1, 4'd13);
      check_eq("bc_dcard1_ok", dcard1, 13);
      check_eq("bc_seq_end", seq_error, 0);

      // Tallies.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      player_win_light = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      player_win_light = 1'b0;
      tick();
      check_eq("t_player_hold", player_wins, 1);
      pulse(1'b1, 1'b1);
      check_eq("t_ties", ties, 1);
      check_eq("t_pw_after_tie", player_wins, 1);
      pulse(1'b0, 1'b1);
      pulse(1'b0, 1'b1);
      check_eq("t_dealer2", dealer_wins, 2);
      pulse(1'b0, 1'b1);
      pulse(1'b0, 1'b1);
      pulse(1'b0, 1'b1);
      check_eq("t_dealer_sat", dealer_wins, 3);
      do_new_round();
      check_eq("t_nr_pw", player_wins, 1);
      check_eq("t_nr_dw", dealer_wins, 3);
      check_eq("t_nr_ties", ties, 1);
      player_win_light = 1'b1;
      new_round = 1'b1;
      tick();
      new_round = 1'b0;
      player_win_light = 1'b0;
      tick();
      check_eq("t_nr_edge", player_wins, 2);

      // Lights already high as reset drops count one cycle later.
      reset = 1'b1;
      player_win_light = 1'b1;
      tick();
      check_eq("t_rst_pw", player_wins, 0);
      check_eq("t_rst_dw", dealer_wins, 0);
      check_eq("t_rst_ties", ties, 0);
      reset = 1'b0;
      tick();
      check_eq("t_rst_edge", player_wins, 1);
      tick();
      check_eq("t_rst_hold", player_wins, 1);
      player_win_light = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
